int_control: RTL and testbench

//  Machine-mode interrupt controller sitting directly upstream of the CSR register file.
//  - Synchronises interrupt sources and builds mip_in.
//  - Arbitrates pending & enabled interrupts and handshakes a pipeline drain with the hazard unit.
//  - Drives int_action/hw_int/int_code into the CSR file, then redirects fetch to the trap vector.

---
 rtl/int_pkg.sv | 19 +
 rtl/irq_sync.sv | 30 +++
 rtl/int_control.sv | 126 ++++++++++++
 tb/tb_int_control.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_pkg.sv
// Shared types and cause codes for the machine-mode interrupt controller.
// Latency: none (declarations only).
// Backpressure: not applicable.
package int_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        TAKE     = 2'd2,
        REDIRECT = 2'd3
    } int_state_t;

    localparam logic [4:0] CAUSE_MSI = 5'd3;
    localparam logic [4:0] CAUSE_MTI = 5'd7;
    localparam logic [4:0] CAUSE_MEI = 5'd11;

    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

endpackage

// File: rtl/irq_sync.sv
// Flop-chain synchroniser for a level-sensitive asynchronous interrupt line.
// Latency: SYNC_STAGES clock edges from d to q.
// Backpressure: none; q simply follows d.
module irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/int_control.sv
// Machine-mode interrupt controller: syncs sources, arbitrates, drains pipe, strobes CSR trap entry, redirects fetch.
// Latency: hit -> irq_req +1 cycle; flush_ack -> int_action +1, pc_redirect +2.
// Backpressure: waits in FLUSH until the hazard unit acks; aborts if the cause or MIE drops first.
module int_control
    import int_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ext_irq_async,
    input  logic        tmr_irq,
    input  logic        sw_irq,
    input  logic [31:0] mip,
    input  logic [31:0] mie,
    input  logic        MIE,
    input  logic [31:0] mtvec,
    input  logic        ret_action,
    input  logic        flush_ack,
    output logic [31:0] mip_in,
    output logic        irq_req,
    output logic        int_action,
    output logic        hw_int,
    output logic [4:0]  int_code,
    output logic        pc_redirect,
    output logic [31:0] trap_pc
);

    int_state_t  state_q, state_d;
    logic [4:0]  cause_q, cause_d;
    logic [4:0]  int_code_q, int_code_d;

    logic        ext_sync;
    logic [31:0] pend;
    logic [4:0]  win_cause;
    logic        hit;
    logic [31:0] vec_base;
    logic [31:0] vec_off;

    irq_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_ext_sync (
        .clk   (clk),
        .reset (reset),
        .d     (ext_irq_async),
        .q     (ext_sync)
    );

    assign mip_in = {20'b0, ext_sync, 3'b0, tmr_irq, 3'b0, sw_irq, 3'b0};
    assign hw_int = 1'b1;

    // Fixed priority MEI > MSI > MTI; every other mip/mie bit is ignored.
    always_comb begin
        pend      = mip & mie;
        win_cause = CAUSE_MTI;
        if (pend[CAUSE_MEI]) begin
            win_cause = CAUSE_MEI;
        end else if (pend[CAUSE_MSI]) begin
            win_cause = CAUSE_MSI;
        end
        hit = MIE & (pend[CAUSE_MEI] | pend[CAUSE_MTI] | pend[CAUSE_MSI]);
    end

    // Modes 2/3 fall back to direct; the add wraps at 32 bits.
    always_comb begin
        vec_base = {mtvec[31:2], 2'b00};
        vec_off  = '0;
        if (mtvec[1:0] == MTVEC_VECTORED) begin
            vec_off = {25'b0, cause_q, 2'b00};
        end
    end

    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        int_code_d  = int_code_q;
        irq_req     = 1'b0;
        int_action  = 1'b0;
        pc_redirect = 1'b0;
        trap_pc     = '0;
        unique case (state_q)
            IDLE: begin
                if (hit && !ret_action) begin
                    state_d = FLUSH;
                    cause_d = win_cause;
                end
            end
            FLUSH: begin
                irq_req = 1'b1;
                if (!pend[cause_q] || !MIE) begin
                    state_d = IDLE;
                end else if (flush_ack) begin
                    state_d    = TAKE;
                    int_code_d = cause_q;
                end
            end
            TAKE: begin
                irq_req    = 1'b1;
                int_action = 1'b1;
                state_d    = REDIRECT;
            end
            REDIRECT: begin
                irq_req     = 1'b1;
                pc_redirect = 1'b1;
                trap_pc     = vec_base + vec_off;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cause_q    <= '0;
            int_code_q <= '0;
        end else begin
            state_q    <= state_d;
            cause_q    <= cause_d;
            int_code_q <= int_code_d;
        end
    end

    assign int_code = int_code_q;

endmodule

// File: tb/tb_int_control.sv
// Directed bench for int_control: expected trap entries/redirects are queued by stimulus and checked by a monitor.
module tb_int_control;

    logic        clk = 1'b0;
    logic        reset;
    logic        ext_irq_async;
    logic        tmr_irq;
    logic        sw_irq;
    logic [31:0] mip;
    logic [31:0] mie;
    logic        MIE;
    logic [31:0] mtvec;
    logic        ret_action;
    logic        flush_ack;
    logic [31:0] mip_in;
    logic        irq_req;
    logic        int_action;
    logic        hw_int;
    logic [4:0]  int_code;
    logic        pc_redirect;
    logic [31:0] trap_pc;

    typedef struct {
        logic [4:0]  code;
        logic [31:0] pc;
        bit          redir;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_take = 0;

    always #5 clk = ~clk;

    // CSR file mirrors mip_in straight back as mip.
    assign mip = mip_in;

    int_control #(.SYNC_STAGES(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .ext_irq_async (ext_irq_async),
        .tmr_irq       (tmr_irq),
        .sw_irq        (sw_irq),
        .mip           (mip),
        .mie           (mie),
        .MIE           (MIE),
        .mtvec         (mtvec),
        .ret_action    (ret_action),
        .flush_ack     (flush_ack),
        .mip_in        (mip_in),
        .irq_req       (irq_req),
        .int_action    (int_action),
        .hw_int        (hw_int),
        .int_code      (int_code),
        .pc_redirect   (pc_redirect),
        .trap_pc       (trap_pc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_irq();
        int n;
        n = 0;
        while (!irq_req && n < 10) begin
            tick();
            n++;
        end
        if (!irq_req) begin
            checks++;
            errors++;
            $display("FAIL wait_irq: got irq_req=0 expected 1 within 10 cycles");
        end
    endtask

    task automatic take_trap(input logic [4:0] code, input logic [31:0] pc, input int ack_delay);
        exp_t e;
        e.code = code; e.pc = pc; e.redir = 1'b1;
        exp_q.push_back(e);
        wait_irq();
        repeat (ack_delay) tick();
        chk("no_take_before_ack", {31'b0, int_action}, 32'd0);
        flush_ack = 1'b1;
        tick();
        flush_ack = 1'b0;
        chk("take_strobe", {31'b0, int_action}, 32'd1);
        MIE = 1'b0;
        tick();
        chk("redirect_strobe", {31'b0, pc_redirect}, 32'd1);
        tick();
        chk("irq_req_released", {31'b0, irq_req}, 32'd0);
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (int_action && pc_redirect) begin
                checks++;
                errors++;
                $display("FAIL strobe_overlap: got int_action=1 pc_redirect=1 expected at most one");
            end
            if (int_action) begin
                n_take++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_take: got int_code=%0d expected no trap", int_code);
                end else begin
                    chk("sb_int_code", {27'b0, int_code}, {27'b0, exp_q[0].code});
                    if (!exp_q[0].redir) void'(exp_q.pop_front());
                end
            end
            if (pc_redirect) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_redirect: got trap_pc=%h expected none", trap_pc);
                end else begin
                    chk("sb_trap_pc", trap_pc, exp_q[0].pc);
                    void'(exp_q.pop_front());
                end
            end
        end
    endtask

    initial begin
        int hi_cnt;
        exp_t e;
        fork
            monitor();
        join_none

        reset = 1'b1; ext_irq_async = 1'b0; tmr_irq = 1'b0; sw_irq = 1'b0;
        mie = '0; MIE = 1'b0; mtvec = '0; ret_action = 1'b0; flush_ack = 1'b0;
        repeat (3) tick();
        chk("rst_irq_req", {31'b0, irq_req}, 32'd0);
        chk("rst_int_action", {31'b0, int_action}, 32'd0);
        chk("rst_pc_redirect", {31'b0, pc_redirect}, 32'd0);
        chk("rst_int_code", {27'b0, int_code}, 32'd0);
        chk("rst_trap_pc", trap_pc, 32'd0);
        chk("rst_mip_in", mip_in, 32'd0);
        chk("rst_hw_int", {31'b0, hw_int}, 32'd1);
        reset = 1'b0;
        tick();

        // 1: timer trap, direct mode, late ack
        mie = 32'h0000_0080; MIE = 1'b1; mtvec = 32'h0000_0100; tmr_irq = 1'b1;
        #1 chk("t1_req_same_cycle", {31'b0, irq_req}, 32'd0);
        tick();
        chk("t1_req_next_cycle", {31'b0, irq_req}, 32'd1);
        take_trap(5'd7, 32'h0000_0100, 3);
        tmr_irq = 1'b0;

        // 2: all three pending, vectored; then mret re-enables with sw still pending
        mie = 32'h0000_0888; mtvec = 32'h0000_0201;
        ext_irq_async = 1'b1; sw_irq = 1'b1; tmr_irq = 1'b1;
        repeat (4) tick();
        MIE = 1'b1;
        take_trap(5'd11, 32'h0000_022C, 1);
        ext_irq_async = 1'b0;
        repeat (3) tick();
        ret_action = 1'b1;
        tick();
        ret_action = 1'b0; MIE = 1'b1;
        take_trap(5'd3, 32'h0000_020C, 1);
        sw_irq = 1'b0; tmr_irq = 1'b0;
        tick();

        // 3: synchroniser latency, then abort when the source drops in FLUSH
        ext_irq_async = 1'b1;
        #1 chk("t3_sync_0", {31'b0, mip_in[11]}, 32'd0);
        tick();
        chk("t3_sync_1", {31'b0, mip_in[11]}, 32'd0);
        tick();
        chk("t3_sync_2", mip_in, 32'h0000_0800);
        ext_irq_async = 1'b0;
        repeat (2) tick();
        chk("t3_sync_fall", mip_in, 32'd0);
        mie = 32'h0000_0080; MIE = 1'b1; tmr_irq = 1'b1;
        tick();
        chk("t3_req", {31'b0, irq_req}, 32'd1);
        tmr_irq = 1'b0;
        tick();
        chk("t3_abort_req", {31'b0, irq_req}, 32'd0);
        flush_ack = 1'b1;
        tick();
        flush_ack = 1'b0;
        chk("t3_abort_no_take", {31'b0, int_action}, 32'd0);
        chk("t3_code_kept", {27'b0, int_code}, 32'd3);
        MIE = 1'b0;
        tick();

        // 4: hit coincident with mret defers a cycle; MIE=0 blocks; mode 3 acts as direct
        mtvec = 32'h0000_0103; MIE = 1'b1; tmr_irq = 1'b1; ret_action = 1'b1;
        tick();
        chk("t4_ret_defers", {31'b0, irq_req}, 32'd0);
        ret_action = 1'b0;
        tick();
        chk("t4_req_after_ret", {31'b0, irq_req}, 32'd1);
        take_trap(5'd7, 32'h0000_0100, 0);
        hi_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (irq_req) hi_cnt++;
        end
        chk("t4_mie0_blocks", hi_cnt, 32'd0);

        // 5: reset in TAKE, normal trap after, reset in FLUSH
        MIE = 1'b1;
        wait_irq();
        e.code = 5'd7; e.pc = '0; e.redir = 1'b0;
        exp_q.push_back(e);
        flush_ack = 1'b1;
        tick();
        flush_ack = 1'b0;
        chk("t5_in_take", {31'b0, int_action}, 32'd1);
        reset = 1'b1;
        tick();
        chk("t5_take_rst_req", {31'b0, irq_req}, 32'd0);
        chk("t5_take_rst_act", {31'b0, int_action}, 32'd0);
        chk("t5_take_rst_redir", {31'b0, pc_redirect}, 32'd0);
        chk("t5_take_rst_code", {27'b0, int_code}, 32'd0);
        reset = 1'b0;
        take_trap(5'd7, 32'h0000_0100, 1);
        MIE = 1'b1;
        wait_irq();
        tick();
        chk("t5_flush_hold", {31'b0, irq_req}, 32'd1);
        reset = 1'b1;
        tick();
        chk("t5_flush_rst_req", {31'b0, irq_req}, 32'd0);
        chk("t5_flush_rst_code", {27'b0, int_code}, 32'd0);
        reset = 1'b0; MIE = 1'b0; tmr_irq = 1'b0;
        repeat (2) tick();

        // 6: vectored target wraps past 2^32
        mie = 32'h0000_0800; ext_irq_async = 1'b1;
        repeat (4) tick();
        mtvec = 32'hFFFF_FFFD; MIE = 1'b1;
        take_trap(5'd11, 32'h0000_0028, 0);
        ext_irq_async = 1'b0;
        repeat (4) tick();

        chk("sb_drained", exp_q.size(), 32'd0);
        chk("take_count", n_take, 32'd7);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
